// File: rtl/ysyx_22040088_idu_pipe.sv
// rtl/ysyx_22040088_idu_pipe.sv - registered RV32/RV64 instruction-decode pipeline stage
//
// Purpose: accepts fetched instructions on a valid/ready handshake, decodes
// them into a compact control bundle and holds that bundle until the execute
// stage takes it. CSR, system and illegal instructions serialise the stage
// until sys_done (or flush) is seen.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_pc, in_inst offered instruction
//   out_valid/out_ready downstream handshake
//   out_pc, out_inst    registered PC and raw instruction
//   out_cls             instruction class (15 = illegal)
//   out_funct3, out_rd, out_rs1, out_rs2  fields of the registered instruction
//   out_imm             decoded immediate, XLEN wide
//   out_word, out_muldiv  RV64 word op, M-extension op
//   out_rf_we/re1/re2   register-file write / read enables
//   flush               squash held bundle and serialisation wait
//   sys_done            serialising instruction has retired
module ysyx_22040088_idu_pipe #(
  parameter int XLEN  = 64,
  parameter bit HAS_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [3:0]      out_cls,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic            out_word,
  output logic            out_muldiv,
  output logic            out_rf_we,
  output logic            out_rf_re1,
  output logic            out_rf_re2,
  input  logic            flush,
  input  logic            sys_done
);

  localparam bit IS64 = (XLEN == 64);

  localparam logic [3:0] CLS_ALUR  = 4'd0;
  localparam logic [3:0] CLS_ALUI  = 4'd1;
  localparam logic [3:0] CLS_LOAD  = 4'd2;
  localparam logic [3:0] CLS_STORE = 4'd3;
  localparam logic [3:0] CLS_BR    = 4'd4;
  localparam logic [3:0] CLS_JAL   = 4'd5;
  localparam logic [3:0] CLS_JALR  = 4'd6;
  localparam logic [3:0] CLS_LUI   = 4'd7;
  localparam logic [3:0] CLS_AUIPC = 4'd8;
  localparam logic [3:0] CLS_CSR   = 4'd9;
  localparam logic [3:0] CLS_SYS   = 4'd10;
  localparam logic [3:0] CLS_ILL   = 4'd15;

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  assign op = in_inst[6:0];
  assign f3 = in_inst[14:12];
  assign f7 = in_inst[31:25];

  logic [3:0]      cls_d;
  logic            word_d, md_d, we_d, re1_d, re2_d, serial_d;
  logic [XLEN-1:0] imm_d;

  // Class decode; anything not explicitly matched stays illegal.
  always_comb begin
    cls_d  = CLS_ILL;
    word_d = 1'b0;
    md_d   = 1'b0;
    case (op)
      7'b0110011: begin
        if (f7 == 7'b0000000) cls_d = CLS_ALUR;
        else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) cls_d = CLS_ALUR;
        else if (f7 == 7'b0000001 && HAS_M) begin cls_d = CLS_ALUR; md_d = 1'b1; end
      end
      7'b0111011: if (IS64) begin
        if (f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)) begin
          cls_d = CLS_ALUR; word_d = 1'b1;
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          cls_d = CLS_ALUR; word_d = 1'b1;
        end else if (f7 == 7'b0000001 && HAS_M && (f3 == 3'b000 || f3[2])) begin
          cls_d = CLS_ALUR; word_d = 1'b1; md_d = 1'b1;
        end
      end
      7'b0010011: begin
        // Shift-immediates: RV64 has a 6-bit shamt, RV32 a 5-bit one.
        if (f3 == 3'b001) begin
          if (IS64 ? (in_inst[31:26] == 6'b000000) : (f7 == 7'b0000000)) cls_d = CLS_ALUI;
        end else if (f3 == 3'b101) begin
          if (IS64 ? (in_inst[31:26] == 6'b000000 || in_inst[31:26] == 6'b010000)
                   : (f7 == 7'b0000000 || f7 == 7'b0100000)) cls_d = CLS_ALUI;
        end else begin
          cls_d = CLS_ALUI;
        end
      end
      7'b0011011: if (IS64) begin
        if (f3 == 3'b000 || (f3 == 3'b001 && f7 == 7'b0000000) ||
            (f3 == 3'b101 && (f7 == 7'b0000000 || f7 == 7'b0100000))) begin
          cls_d = CLS_ALUI; word_d = 1'b1;
        end
      end
      7'b0000011: if (f3 != 3'b111 && (IS64 || (f3 != 3'b011 && f3 != 3'b110))) cls_d = CLS_LOAD;
      7'b0100011: if (!f3[2] && (IS64 || f3 != 3'b011)) cls_d = CLS_STORE;
      7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) cls_d = CLS_BR;
      7'b1101111: cls_d = CLS_JAL;
      7'b1100111: if (f3 == 3'b000) cls_d = CLS_JALR;
      7'b0110111: cls_d = CLS_LUI;
      7'b0010111: cls_d = CLS_AUIPC;
      7'b1110011: begin
        if (f3 != 3'b000 && f3 != 3'b100) cls_d = CLS_CSR;
        else if (in_inst == 32'h0000_0073 || in_inst == 32'h0010_0073 ||
                 in_inst == 32'h3020_0073) cls_d = CLS_SYS;
      end
      default: cls_d = CLS_ILL;
    endcase
  end

  // Immediate selection and register-file enables follow the class.
  always_comb begin
    imm_d = '0;
    we_d  = 1'b0;
    re1_d = 1'b0;
    re2_d = 1'b0;
    case (cls_d)
      CLS_ALUR:  begin we_d = 1'b1; re1_d = 1'b1; re2_d = 1'b1; end
      CLS_ALUI, CLS_LOAD, CLS_JALR: begin
        imm_d = XLEN'($signed(in_inst[31:20])); we_d = 1'b1; re1_d = 1'b1;
      end
      CLS_STORE: begin
        imm_d = XLEN'($signed({in_inst[31:25], in_inst[11:7]})); re1_d = 1'b1; re2_d = 1'b1;
      end
      CLS_BR: begin
        imm_d = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
        re1_d = 1'b1; re2_d = 1'b1;
      end
      CLS_JAL: begin
        imm_d = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
        we_d = 1'b1;
      end
      CLS_LUI, CLS_AUIPC: begin
        imm_d = XLEN'($signed({in_inst[31:12], 12'b0})); we_d = 1'b1;
      end
      CLS_CSR: begin
        imm_d = XLEN'(in_inst[31:20]); we_d = 1'b1; re1_d = !f3[2];
      end
      CLS_SYS: imm_d = XLEN'($signed(in_inst[31:20]));
      default: imm_d = '0;
    endcase
    if (in_inst[11:7] == 5'd0) we_d = 1'b0;
  end

  assign serial_d = (cls_d == CLS_CSR) || (cls_d == CLS_SYS) || (cls_d == CLS_ILL);

  logic valid_q, wait_q, accept;
  assign in_ready = (!valid_q || out_ready) && !wait_q && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= 1'b0;
      wait_q  <= 1'b0;
    end else begin
      if (accept) valid_q <= 1'b1;
      else if (out_ready) valid_q <= 1'b0;
      if (sys_done) wait_q <= 1'b0;
      else if (accept && serial_d) wait_q <= 1'b1;
    end
  end

  logic [XLEN-1:0] pc_q, imm_q;
  logic [31:0]     inst_q;
  logic [3:0]      cls_q;
  logic            word_q, md_q, we_q, re1_q, re2_q;

  // accept is already gated by flush through in_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0; imm_q <= '0; inst_q <= '0; cls_q <= '0;
      word_q <= 1'b0; md_q <= 1'b0; we_q <= 1'b0; re1_q <= 1'b0; re2_q <= 1'b0;
    end else if (accept) begin
      pc_q <= in_pc; imm_q <= imm_d; inst_q <= in_inst; cls_q <= cls_d;
      word_q <= word_d; md_q <= md_d; we_q <= we_d; re1_q <= re1_d; re2_q <= re2_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_pc     = pc_q;
  assign out_inst   = inst_q;
  assign out_cls    = cls_q;
  assign out_funct3 = inst_q[14:12];
  assign out_rd     = inst_q[11:7];
  assign out_rs1    = inst_q[19:15];
  assign out_rs2    = inst_q[24:20];
  assign out_imm    = imm_q;
  assign out_word   = word_q;
  assign out_muldiv = md_q;
  assign out_rf_we  = we_q;
  assign out_rf_re1 = re1_q;
  assign out_rf_re2 = re2_q;

endmodule

// File: tb/tb_ysyx_22040088_idu_pipe.sv
// tb/tb_ysyx_22040088_idu_pipe.sv - self-checking bench for the decode pipeline stage
module tb_ysyx_22040088_idu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, flush, sys_done;
  logic [63:0] in_pc;
  logic [31:0] in_inst;

  // u0: XLEN=64 HAS_M=1, u1: XLEN=32 HAS_M=1, u2: XLEN=64 HAS_M=0
  logic        o0_rdy, o0_v, o0_w, o0_md, o0_we, o0_r1, o0_r2;
  logic [63:0] o0_pc, o0_imm;
  logic [31:0] o0_inst;
  logic [3:0]  o0_cls;
  logic [2:0]  o0_f3;
  logic [4:0]  o0_rd, o0_rs1, o0_rs2;
  logic        o1_rdy, o1_v, o1_w, o1_md, o1_we, o1_r1, o1_r2;
  logic [31:0] o1_pc, o1_imm;
  logic [31:0] o1_inst;
  logic [3:0]  o1_cls;
  logic [2:0]  o1_f3;
  logic [4:0]  o1_rd, o1_rs1, o1_rs2;
  logic        o2_rdy, o2_v, o2_w, o2_md, o2_we, o2_r1, o2_r2;
  logic [63:0] o2_pc, o2_imm;
  logic [31:0] o2_inst;
  logic [3:0]  o2_cls;
  logic [2:0]  o2_f3;
  logic [4:0]  o2_rd, o2_rs1, o2_rs2;

  ysyx_22040088_idu_pipe #(.XLEN(64), .HAS_M(1'b1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o0_rdy), .in_pc(in_pc),
    .in_inst(in_inst), .out_valid(o0_v), .out_ready(out_ready), .out_pc(o0_pc),
    .out_inst(o0_inst), .out_cls(o0_cls), .out_funct3(o0_f3), .out_rd(o0_rd),
    .out_rs1(o0_rs1), .out_rs2(o0_rs2), .out_imm(o0_imm), .out_word(o0_w),
    .out_muldiv(o0_md), .out_rf_we(o0_we), .out_rf_re1(o0_r1), .out_rf_re2(o0_r2),
    .flush(flush), .sys_done(sys_done));

  ysyx_22040088_idu_pipe #(.XLEN(32), .HAS_M(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o1_rdy), .in_pc(in_pc[31:0]),
    .in_inst(in_inst), .out_valid(o1_v), .out_ready(out_ready), .out_pc(o1_pc),
    .out_inst(o1_inst), .out_cls(o1_cls), .out_funct3(o1_f3), .out_rd(o1_rd),
    .out_rs1(o1_rs1), .out_rs2(o1_rs2), .out_imm(o1_imm), .out_word(o1_w),
    .out_muldiv(o1_md), .out_rf_we(o1_we), .out_rf_re1(o1_r1), .out_rf_re2(o1_r2),
    .flush(flush), .sys_done(sys_done));

  ysyx_22040088_idu_pipe #(.XLEN(64), .HAS_M(1'b0)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o2_rdy), .in_pc(in_pc),
    .in_inst(in_inst), .out_valid(o2_v), .out_ready(out_ready), .out_pc(o2_pc),
    .out_inst(o2_inst), .out_cls(o2_cls), .out_funct3(o2_f3), .out_rd(o2_rd),
    .out_rs1(o2_rs1), .out_rs2(o2_rs2), .out_imm(o2_imm), .out_word(o2_w),
    .out_muldiv(o2_md), .out_rf_we(o2_we), .out_rf_re1(o2_r1), .out_rf_re2(o2_r2),
    .flush(flush), .sys_done(sys_done));

  int          sel;
  logic        s_rdy, s_v, s_w, s_md, s_we, s_r1, s_r2;
  logic [63:0] s_pc, s_imm;
  logic [31:0] s_inst;
  logic [3:0]  s_cls;
  logic [2:0]  s_f3;
  logic [4:0]  s_rd, s_rs1, s_rs2;

  always_comb begin
    s_rdy = o0_rdy; s_v = o0_v; s_w = o0_w; s_md = o0_md; s_we = o0_we; s_r1 = o0_r1;
    s_r2 = o0_r2; s_pc = o0_pc; s_imm = o0_imm; s_inst = o0_inst; s_cls = o0_cls;
    s_f3 = o0_f3; s_rd = o0_rd; s_rs1 = o0_rs1; s_rs2 = o0_rs2;
    if (sel == 1) begin
      s_rdy = o1_rdy; s_v = o1_v; s_w = o1_w; s_md = o1_md; s_we = o1_we; s_r1 = o1_r1;
      s_r2 = o1_r2; s_pc = {32'b0, o1_pc}; s_imm = {32'b0, o1_imm}; s_inst = o1_inst;
      s_cls = o1_cls; s_f3 = o1_f3; s_rd = o1_rd; s_rs1 = o1_rs1; s_rs2 = o1_rs2;
    end else if (sel == 2) begin
      s_rdy = o2_rdy; s_v = o2_v; s_w = o2_w; s_md = o2_md; s_we = o2_we; s_r1 = o2_r1;
      s_r2 = o2_r2; s_pc = o2_pc; s_imm = o2_imm; s_inst = o2_inst; s_cls = o2_cls;
      s_f3 = o2_f3; s_rd = o2_rd; s_rs1 = o2_rs1; s_rs2 = o2_rs2;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] inst;
    int          dut;
    logic [3:0]  cls;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic        we, re1, re2, word, md;
  } vec_t;

  localparam int NV = 18;
  vec_t vt[NV];

  initial begin
    vt[0]  = '{32'h0050_0093, 0, 4'd1,  64'd5,                 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // addi
    vt[1]  = '{32'hFE00_0EE3, 0, 4'd4,  64'hFFFF_FFFF_FFFF_FFFC, 5'd29, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // beq -4
    vt[2]  = '{32'h0001_3083, 1, 4'd15, 64'd0,                 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // ld rv32
    vt[3]  = '{32'h0001_3083, 0, 4'd2,  64'd0,                 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // ld rv64
    vt[4]  = '{32'h0220_81B3, 2, 4'd15, 64'd0,                 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // mul no M
    vt[5]  = '{32'h0220_81B3, 0, 4'd0,  64'd0,                 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}; // mul
    vt[6]  = '{32'h3000_9073, 0, 4'd9,  64'h300,               5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // csrrw
    vt[7]  = '{32'h0000_0073, 0, 4'd10, 64'd0,                 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // ecall
    vt[8]  = '{32'h0000_0000, 0, 4'd15, 64'd0,                 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // zero
    vt[9]  = '{32'h1234_50B7, 0, 4'd7,  64'h1234_5000,         5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // lui
    vt[10] = '{32'h0020_A223, 0, 4'd3,  64'd4,                 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // sw
    vt[11] = '{32'h0080_00EF, 0, 4'd5,  64'd8,                 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // jal +8
    vt[12] = '{32'hFFF0_809B, 0, 4'd1,  64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // addiw
    vt[13] = '{32'hFFF0_809B, 1, 4'd15, 64'd0,                 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // addiw rv32
    vt[14] = '{32'h0200_9093, 1, 4'd15, 64'd0,                 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // slli 32 rv32
    vt[15] = '{32'h0200_9093, 0, 4'd1,  64'd32,                5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // slli 32 rv64
    vt[16] = '{32'h4020_81B3, 0, 4'd0,  64'd0,                 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // sub
    vt[17] = '{32'h3020_0073, 0, 4'd10, 64'h302,               5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // mret

    sel = 0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; sys_done = 1'b0;
    in_pc = '0; in_inst = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset_valid", 64'(s_v), 64'd0);
    chk("reset_ready", 64'(s_rdy), 64'd1);
    chk("reset_cls", 64'(s_cls), 64'd0);
    chk("reset_imm", s_imm, 64'd0);
    chk("reset_pc", s_pc, 64'd0);

    // Table: flush to a clean stage, accept one instruction, check bundle.
    for (int i = 0; i < NV; i++) begin
      logic [63:0] pc, mask;
      logic        serial;
      flush = 1'b1; in_valid = 1'b0; tick(); flush = 1'b0;
      pc = 64'h8000_0000 + 64'(i * 4);
      sel = vt[i].dut;
      mask = (vt[i].dut == 1) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      serial = (vt[i].cls == 4'd9) || (vt[i].cls == 4'd10) || (vt[i].cls == 4'd15);
      in_valid = 1'b1; in_inst = vt[i].inst; in_pc = pc; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_valid", i), 64'(s_v), 64'd1);
      chk($sformatf("v%0d_cls", i), 64'(s_cls), 64'(vt[i].cls));
      chk($sformatf("v%0d_imm", i), s_imm, vt[i].imm & mask);
      chk($sformatf("v%0d_pc", i), s_pc, pc & mask);
      chk($sformatf("v%0d_inst", i), 64'(s_inst), 64'(vt[i].inst));
      chk($sformatf("v%0d_rd", i), 64'(s_rd), 64'(vt[i].rd));
      chk($sformatf("v%0d_fields", i), {49'b0, s_f3, s_rs1, s_rs2},
          {49'b0, vt[i].inst[14:12], vt[i].inst[19:15], vt[i].inst[24:20]});
      chk($sformatf("v%0d_en", i), {61'b0, s_we, s_r1, s_r2},
          {61'b0, vt[i].we, vt[i].re1, vt[i].re2});
      chk($sformatf("v%0d_word_md", i), {62'b0, s_w, s_md}, {62'b0, vt[i].word, vt[i].md});
      chk($sformatf("v%0d_ready", i), 64'(s_rdy), 64'(!serial));
    end
    sel = 0;

    // Stall: held beq stays stable for 3 cycles, the offered addi waits.
    flush = 1'b1; tick(); flush = 1'b0;
    in_valid = 1'b1; in_inst = 32'hFE00_0EE3; in_pc = 64'h100; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_inst = 32'h0050_0093; in_pc = 64'h104;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d_valid", k), 64'(o0_v), 64'd1);
      chk($sformatf("stall%0d_cls", k), 64'(o0_cls), 64'd4);
      chk($sformatf("stall%0d_imm", k), o0_imm, 64'hFFFF_FFFF_FFFF_FFFC);
      chk($sformatf("stall%0d_pc", k), o0_pc, 64'h100);
      chk($sformatf("stall%0d_ready", k), 64'(o0_rdy), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_ready", 64'(o0_rdy), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("stall_next_cls", 64'(o0_cls), 64'd1);
    chk("stall_next_pc", o0_pc, 64'h104);

    // Serialisation: csrrw then ecall block in_ready until sys_done.
    for (int s = 0; s < 2; s++) begin
      logic [31:0] sinst;
      sinst = (s == 0) ? 32'h3000_9073 : 32'h0000_0073;
      flush = 1'b1; tick(); flush = 1'b0;
      in_valid = 1'b1; in_inst = sinst; out_ready = 1'b1;
      tick();
      chk($sformatf("ser%0d_cls", s), 64'(o0_cls), (s == 0) ? 64'd9 : 64'd10);
      chk($sformatf("ser%0d_ready0", s), 64'(o0_rdy), 64'd0);
      in_inst = 32'h0050_0093;
      for (int k = 0; k < 3; k++) begin
        tick();
        chk($sformatf("ser%0d_wait%0d_ready", s, k), 64'(o0_rdy), 64'd0);
        chk($sformatf("ser%0d_wait%0d_valid", s, k), 64'(o0_v), 64'd0);
      end
      sys_done = 1'b1;
      #1;
      chk($sformatf("ser%0d_done_cycle_ready", s), 64'(o0_rdy), 64'd0);
      tick();
      sys_done = 1'b0;
      #1;
      chk($sformatf("ser%0d_after_done_ready", s), 64'(o0_rdy), 64'd1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("ser%0d_resume_cls", s), 64'(o0_cls), 64'd1);
      chk($sformatf("ser%0d_resume_valid", s), 64'(o0_v), 64'd1);
    end

    // Back-to-back stream of four addi with out_ready held high.
    flush = 1'b1; tick(); flush = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_inst = (32'(k) << 20) | 32'h0000_0093;
      tick();
      chk($sformatf("stream%0d_valid", k), 64'(o0_v), 64'd1);
      chk($sformatf("stream%0d_imm", k), o0_imm, 64'(k));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", 64'(o0_v), 64'd0);

    // Flush while a held ecall is waiting.
    in_valid = 1'b1; in_inst = 32'h0000_0073; out_ready = 1'b0;
    tick();
    chk("fl_held_valid", 64'(o0_v), 64'd1);
    chk("fl_held_cls", 64'(o0_cls), 64'd10);
    flush = 1'b1; in_inst = 32'h0050_0093;
    #1;
    chk("fl_cycle_ready", 64'(o0_rdy), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_after_valid", 64'(o0_v), 64'd0);
    chk("fl_after_ready", 64'(o0_rdy), 64'd1);

    // Reset while a csr bundle is held and waiting.
    in_valid = 1'b1; in_inst = 32'h3000_9073; out_ready = 1'b0;
    tick();
    chk("rw_held_valid", 64'(o0_v), 64'd1);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("rw_valid", 64'(o0_v), 64'd0);
    chk("rw_ready", 64'(o0_rdy), 64'd1);
    chk("rw_cls", 64'(o0_cls), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22040088_idu_pipe.md
# ysyx_22040088_idu_pipe

Registered instruction-decode stage that sits between the IFU output and the EXU input of the ysyx_22040088 core. It accepts fetched instructions over a valid/ready handshake, decodes them into a compact control bundle, and holds the bundle in a pipeline register until the downstream stage takes it. The decode is parametrised for RV32/RV64 and for an optional M extension, and illegal encodings are flagged as a real output rather than tied off. CSR and system instructions are serialised: nothing new is accepted until the core signals they have retired.

## Interface
- XLEN, 64, datapath width; legal values 32 or 64.
- HAS_M, 1, 1 enables M-extension decode; 0 makes all M encodings illegal.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  IFU offers an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_pc  in  XLEN  PC of the offered instruction.
- in_inst  in  32  raw instruction.
- out_valid  out  1  bundle valid.
- out_ready  in  1  EXU takes the bundle.
- out_pc  out  XLEN  registered PC.
- out_inst  out  32  registered instruction.
- out_cls  out  4  class: 0 ALU-R, 1 ALU-I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 CSR, 10 SYS (ecall/ebreak/mret), 15 ILLEGAL.
- out_funct3  out  3  inst[14:12].
- out_rd, out_rs1, out_rs2  out  5 each  register indices.
- out_imm  out  XLEN  immediate (see Operation).
- out_word  out  1  RV64 *W op or *IW op.
- out_muldiv  out  1  M-extension op.
- out_rf_we, out_rf_re1, out_rf_re2  out  1 each  register-file write and read enables.
- flush  in  1  squash the held bundle and any serialisation wait.
- sys_done  in  1  pulse: the serialising instruction has retired.

## Operation
- Stage states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
  - WAIT_SYS: serialising; out_valid may be 0 or 1.
- in_ready = (!out_valid | out_ready) & !wait_sys & !flush.
- Accept = in_valid & in_ready. On accept, the decoded bundle is registered and out_valid=1 the next cycle. A bundle taken this cycle may be replaced by a new one in the same cycle, giving full throughput.
- Stall: out_valid & !out_ready means every out_* holds stable and in_ready=0.
- Serialisation: accepting class 9, 10 or 15 sets wait_sys. wait_sys clears on sys_done or flush. If sys_done and accept coincide, sys_done wins and the accept cannot happen because in_ready=0.
- Flush:
  - Next cycle out_valid=0 and wait_sys=0.
  - No accept occurs in the flush cycle.
  - Flush overrides out_ready, sys_done and in_valid.
- Illegal cases, all decoded as class 15:
  - Unknown opcode/funct3/funct7 combinations.
  - XLEN=32 with ld, sd, lwu, any opcode 0011011/0111011, or an RV32 shift-immediate with inst[25]=1.
  - HAS_M=0 with funct7=0000001 on opcodes 0110011/0111011.
  - The all-zero instruction.
- out_imm rules:
  - I-type (1, 2, 6 and the SYS class): sext(inst[31:20]).
  - S-type: sext({inst[31:25], inst[11:7]}).
  - B-type: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - J-type: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - U-type: sext({inst[31:12], 12'b0}).
  - CSR: zext(inst[31:20]).
  - R-type and illegal: 0.
  - All sign-extension is to XLEN.
- Register-file enables:
  - rf_we=1 for classes 0, 1, 2, 5, 6, 7, 8, 9. It is 0 whenever rd=0.
  - rf_re1=1 for classes 0, 1, 2, 3, 4, 6, and for CSR with funct3[2]=0.
  - rf_re2=1 for classes 0, 3, 4.
  - Class 15 forces all three enables to 0.

## Timing
- Reset: out_valid=0, wait_sys=0, all registered out_* zero, in_ready=1 the first cycle after reset (if no flush).
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction per cycle with out_ready held high.
- Reset mid-stall or mid-wait discards the bundle and clears wait_sys.

## Test plan
- Reset, XLEN=64: in 0x00500093 (addi x1,x0,5), pc 0x80000000. Next cycle out_valid=1, cls=1, rd=1, imm=5, rf_we=1, rf_re1=1.
- Branch decode: 0xFE000EE3 (beq x0,x0,-4). Required: cls=4, imm=0xFFFFFFFFFFFFFFFC, rf_we=0, rf_re1=1, rf_re2=1. Hold out_ready=0 for 3 cycles: outputs stable and in_ready=0 throughout.
- Width and M gating:
  - 0x00013083 (ld) with XLEN=32: cls=15, wait_sys set.
  - With XLEN=64: cls=2.
  - 0x022081B3 (mul) with HAS_M=0: cls=15. With HAS_M=1: cls=0, muldiv=1.
- Serialisation: 0x30009073 (csrrw x0,mstatus,x1) gives cls=9, imm=0x300, rf_we=0. in_ready stays 0 until a sys_done pulse and is 1 the following cycle. 0x00000073 (ecall) gives cls=10 with the same behaviour.
- Flush and back-to-back:
  - Stream 4 addi with out_ready=1: 4 consecutive valid cycles.
  - Assert flush with a held bundle during WAIT_SYS: next cycle out_valid=0, in_ready=1, no accept in the flush cycle.
